// File: rtl/powlib_edgecap_pkg.sv
// Shared definitions for the powlib_edgecap multi-channel edge capture unit.
//  - POS / NEG / ANY : edge-mode encodings formed as {negen, posen} per channel.
//  - clog2           : width helper for the debounce counter, never narrower than 1 bit.
package powlib_edgecap_pkg;

    localparam logic [1:0] POS = 2'b01;
    localparam logic [1:0] NEG = 2'b10;
    localparam logic [1:0] ANY = 2'b11;

    // Number of bits needed to count 0..value-1; at least 1.
    function automatic int clog2(input int value);
        int width;
        int span;
        width = 0;
        span  = 1;
        while (span < value) begin
            span  = span * 2;
            width = width + 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/powlib_edgecap_ch.sv
// One edge-capture channel: debounce filter, edge detect, sticky pending flag and
// saturating event counter.
// Ports:
//  clk, rst    clock and synchronous active-high reset
//  s           synchronized input level
//  smp_en      sample qualifier; filter state advances only when high
//  posen/negen rising / falling edge enables
//  clr         clear of pend and cnt (an accepted event in the same cycle wins)
//  lvl         filtered level
//  evt         one-cycle pulse for an enabled accepted edge
//  pend        sticky pending flag
//  pend_next   next-state of pend, lets the top register irq in step with pend
//  cnt         saturating event counter
module powlib_edgecap_ch
    import powlib_edgecap_pkg::*;
#(
    parameter int   DBN      = 1,
    parameter int   CW       = 8,
    parameter logic INIT_LVL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s,
    input  logic          smp_en,
    input  logic          posen,
    input  logic          negen,
    input  logic          clr,
    output logic          lvl,
    output logic          evt,
    output logic          pend,
    output logic          pend_next,
    output logic [CW-1:0] cnt
);

    localparam int            DW        = clog2(DBN);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DBN - 1);

    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          lvl_q, lvl_d;
    logic          evt_q, evt_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    logic          hit;
    logic [1:0]    edge_mode;

    always_comb begin
        dcnt_d    = dcnt_q;
        lvl_d     = lvl_q;
        accept    = 1'b0;
        edge_mode = {negen, posen};

        // dcnt counts consecutive qualified samples that disagree with lvl;
        // the DBN-th such sample flips the filtered level.
        if (smp_en) begin
            if (s == lvl_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DCNT_LAST) begin
                lvl_d  = s;
                dcnt_d = '0;
                accept = 1'b1;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end

        // Only accepts whose new level matches an enabled edge count as events.
        hit    = accept && ((edge_mode & (lvl_d ? POS : NEG)) != 2'b00);
        evt_d  = hit;
        pend_d = hit | (pend_q & ~clr);

        cnt_d = cnt_q;
        if (clr) begin
            // An event arriving with clr is kept so it is never lost.
            cnt_d = hit ? CW'(1) : '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt_q <= '0;
            lvl_q  <= INIT_LVL;
            evt_q  <= 1'b0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            dcnt_q <= dcnt_d;
            lvl_q  <= lvl_d;
            evt_q  <= evt_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign lvl       = lvl_q;
    assign evt       = evt_q;
    assign pend      = pend_q;
    assign pend_next = pend_d;
    assign cnt       = cnt_q;

endmodule

// File: rtl/powlib_edgecap.sv
// Multi-channel edge capture unit.
// Raw levels pass through an optional SS-deep synchronizer, then each of W channels
// debounces, detects enabled edges, and keeps a pending flag and an event counter.
// Ports:
//  clk, rst     clock and synchronous active-high reset
//  in[W]        raw channel levels
//  vld          sample qualifier (only honoured when EVLD=1)
//  posen/negen  per-channel rising/falling edge enables
//  mask         per-channel interrupt enable
//  clr          per-channel clear pulse for pend and cnt
//  lvl, evt, pend, cnt  per-channel status (cnt of channel i at [i*CW +: CW])
//  irq          registered OR of pend & mask
module powlib_edgecap
    import powlib_edgecap_pkg::*;
#(
    parameter int           W    = 7,
    parameter logic [W-1:0] INIT = '0,
    parameter int           SS   = 2,
    parameter int           DBN  = 1,
    parameter int           CW   = 8,
    parameter int           EVLD = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    in,
    input  logic            vld,
    input  logic [W-1:0]    posen,
    input  logic [W-1:0]    negen,
    input  logic [W-1:0]    mask,
    input  logic [W-1:0]    clr,
    output logic [W-1:0]    lvl,
    output logic [W-1:0]    evt,
    output logic [W-1:0]    pend,
    output logic [W*CW-1:0] cnt,
    output logic            irq
);

    logic [W-1:0] s;
    logic [W-1:0] pend_next;
    logic         smp_en;
    logic         irq_q, irq_d;

    assign smp_en = (EVLD != 0) ? vld : 1'b1;

    generate
        if (SS == 0) begin : g_nosync
            assign s = in;
        end else begin : g_sync
            logic [W-1:0] sync_q [SS];
            logic [W-1:0] sync_d [SS];
            genvar gi;
            for (gi = 0; gi < SS; gi = gi + 1) begin : g_stage
                if (gi == 0) begin : g_first
                    assign sync_d[gi] = in;
                end else begin : g_next
                    assign sync_d[gi] = sync_q[gi-1];
                end
                // Synchronizer shifts every cycle; vld only gates the filter.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        sync_q[gi] <= INIT;
                    end else begin
                        sync_q[gi] <= sync_d[gi];
                    end
                end
            end
            assign s = sync_q[SS-1];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < W; gi = gi + 1) begin : g_ch
            powlib_edgecap_ch #(
                .DBN      (DBN),
                .CW       (CW),
                .INIT_LVL (INIT[gi])
            ) u_ch (
                .clk       (clk),
                .rst       (rst),
                .s         (s[gi]),
                .smp_en    (smp_en),
                .posen     (posen[gi]),
                .negen     (negen[gi]),
                .clr       (clr[gi]),
                .lvl       (lvl[gi]),
                .evt       (evt[gi]),
                .pend      (pend[gi]),
                .pend_next (pend_next[gi]),
                .cnt       (cnt[gi*CW +: CW])
            );
        end
    endgenerate

    // Built from next-state pend so irq rises and falls in the same cycle as pend.
    always_comb begin
        irq_d = |(pend_next & mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule
